// File: rtl/mbc5_multicart_sync_if.sv
// Cartridge-edge bus bundle for the synchronous MBC5 multicart mapper.
// The host side drives the GB bus; the mapper drives the memory selects and the host-reset line.
interface mbc5_multicart_sync_if #(
    parameter int ROM_AW = 23,
    parameter int RAM_AW = 17
);
    logic [15:0]        GB_A;
    logic [7:0]         GB_D;
    logic               nGB_WR;
    logic [ROM_AW-15:0] ROM_A;
    logic [RAM_AW-14:0] RAM_A;
    logic               nROM_CS;
    logic               nRAM_CS;
    logic               GB_RST_o;
    logic               GB_RST_oe;

    modport master (
        output GB_A, GB_D, nGB_WR,
        input  ROM_A, RAM_A, nROM_CS, nRAM_CS, GB_RST_o, GB_RST_oe
    );

    modport slave (
        input  GB_A, GB_D, nGB_WR,
        output ROM_A, RAM_A, nROM_CS, nRAM_CS, GB_RST_o, GB_RST_oe
    );
endinterface

// File: rtl/mbc5_multicart_sync.sv
// MBC5-style mapper with 2^SLOT_BITS game slots, a one-way menu lock and a retriggerable host-reset pulse.
// Host writes are synchronised into the osc_sig domain and committed on the rising edge of the write strobe.
module mbc5_multicart_sync #(
    parameter int ROM_AW      = 23,
    parameter int RAM_AW      = 17,
    parameter int SLOT_BITS   = 2,
    parameter int RST_CYCLES  = 42016,
    parameter int SYNC_STAGES = 2,
    parameter int CTRL_BIT    = 4
) (
    input logic                     osc_sig,
    input logic                     rst,
    mbc5_multicart_sync_if.slave    bus
);

    localparam int ROM_W  = ROM_AW - 14;
    localparam int RAM_W  = RAM_AW - 13;
    localparam int ROM_LO = ROM_W - SLOT_BITS;
    localparam int RAM_LO = RAM_W - SLOT_BITS;
    localparam int CNT_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RST_CYCLES - 1);

    typedef enum logic {PULSE_IDLE, PULSE_ACTIVE} pulse_state_t;

    logic [SYNC_STAGES-1:0] wr_sync;
    logic                   wr_synced;
    logic                   wr_prev;
    logic                   commit;
    logic [3:0]             cap_a;
    logic [7:0]             cap_d;

    logic [8:0]             rom_bank;
    logic [CTRL_BIT:0]      ram_bank;
    logic                   ram_en;
    logic                   sel_en;
    logic                   locked;
    logic [SLOT_BITS-1:0]   slot;

    logic                   win;
    logic                   trigger;
    logic [CNT_W-1:0]       pulse_cnt;
    pulse_state_t           pulse_state;
    pulse_state_t           pulse_next;
    logic [8:0]             rom_pick;
    logic                   unused_addr_bits;

    assign wr_synced        = wr_sync[SYNC_STAGES-1];
    assign commit           = wr_synced && !wr_prev;
    assign win              = ram_bank[CTRL_BIT] && !locked;
    assign trigger          = commit && (cap_a == 4'h4) && win;
    assign unused_addr_bits = ^bus.GB_A[11:0];

    // Synchroniser starts high so that leaving reset never looks like the end of a write.
    always_ff @(posedge osc_sig or posedge rst) begin
        if (rst) begin
            wr_sync <= '1;
            wr_prev <= 1'b1;
        end else begin
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], bus.nGB_WR};
            wr_prev <= wr_synced;
        end
    end

    always_ff @(posedge osc_sig or posedge rst) begin
        if (rst) begin
            cap_a <= 4'h0;
            cap_d <= 8'h00;
        end else if (!wr_synced) begin
            cap_a <= bus.GB_A[15:12];
            cap_d <= bus.GB_D;
        end
    end

    // Control window writes (A/B) only take effect while the window bit is set and the menu is unlocked.
    always_ff @(posedge osc_sig or posedge rst) begin
        if (rst) begin
            rom_bank <= 9'd1;
            ram_bank <= '0;
            ram_en   <= 1'b0;
            sel_en   <= 1'b0;
            locked   <= 1'b0;
            slot     <= '0;
        end else if (commit) begin
            case (cap_a)
                4'h0, 4'h1: ram_en <= (cap_d[3:0] == 4'hA);
                4'h2:       rom_bank[7:0] <= cap_d;
                4'h3:       rom_bank[8] <= cap_d[0];
                4'h4, 4'h5: begin
                    ram_bank[CTRL_BIT-1:0] <= cap_d[CTRL_BIT-1:0];
                    ram_bank[CTRL_BIT]     <= !sel_en && !locked && cap_d[CTRL_BIT];
                end
                4'hA: begin
                    if (win) begin
                        sel_en <= cap_d[0];
                        locked <= locked | cap_d[7];
                    end
                end
                4'hB: begin
                    if (win) begin
                        slot <= cap_d[SLOT_BITS-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge osc_sig or posedge rst) begin
        if (rst) begin
            pulse_state <= PULSE_IDLE;
        end else begin
            pulse_state <= pulse_next;
        end
    end

    // A trigger always wins, including in the cycle the previous pulse would have ended.
    always_comb begin
        pulse_next = pulse_state;
        case (pulse_state)
            PULSE_IDLE:   if (trigger) pulse_next = PULSE_ACTIVE;
            PULSE_ACTIVE: if (!trigger && pulse_cnt == CNT_MAX) pulse_next = PULSE_IDLE;
            default:      pulse_next = PULSE_IDLE;
        endcase
    end

    always_comb begin
        bus.GB_RST_oe = (pulse_state == PULSE_ACTIVE);
        bus.GB_RST_o  = 1'b0;
    end

    always_ff @(posedge osc_sig or posedge rst) begin
        if (rst) begin
            pulse_cnt <= '0;
        end else if (trigger) begin
            pulse_cnt <= '0;
        end else if (pulse_state == PULSE_ACTIVE) begin
            pulse_cnt <= (pulse_cnt == CNT_MAX) ? '0 : pulse_cnt + CNT_W'(1);
        end
    end

    // Bank 0 in the upper ROM window is deliberately not remapped to bank 1.
    always_comb begin
        rom_pick = (bus.GB_A[15:14] == 2'b00) ? 9'd0 : rom_bank;
        if (sel_en) begin
            bus.ROM_A = {slot, ROM_LO'(rom_pick)};
            bus.RAM_A = {slot, RAM_LO'(ram_bank)};
        end else begin
            bus.ROM_A = ROM_W'(rom_pick);
            bus.RAM_A = RAM_W'(ram_bank[CTRL_BIT-1:0]);
        end
        bus.nROM_CS = bus.GB_A[15];
        bus.nRAM_CS = !((bus.GB_A[15:13] == 3'b101) && ram_en && !ram_bank[CTRL_BIT]);
    end

endmodule

// File: tb/tb_mbc5_multicart_sync.sv
// Bench for mbc5_multicart_sync: directed scenarios plus random writes against a behavioural mapper model.
// The reset pulse length is shortened so the retrigger scenario stays short.
module tb_mbc5_multicart_sync;

    localparam int ROM_AW = 23;
    localparam int RAM_AW = 17;
    localparam int SB     = 2;
    localparam int R      = 420;
    localparam int SS     = 2;
    localparam int CB     = 4;
    localparam int ROM_W  = ROM_AW - 14;
    localparam int RAM_W  = RAM_AW - 13;
    localparam int RETRIG = 200;

    logic osc_sig;
    logic rst;

    mbc5_multicart_sync_if #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) bus ();

    mbc5_multicart_sync #(
        .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .SLOT_BITS(SB),
        .RST_CYCLES(R), .SYNC_STAGES(SS), .CTRL_BIT(CB)
    ) dut (
        .osc_sig(osc_sig),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int m_rom, m_ram, m_slot, m_pulse;
    bit m_ram_en, m_sel, m_locked;
    int pend_a, pend_d;

    initial begin
        osc_sig = 1'b0;
        forever #5 osc_sig = ~osc_sig;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic int expRom(input int addr);
        int pre;
        pre = (addr < 'h4000) ? 0 : m_rom;
        pre = pre % (1 << ROM_W);
        if (m_sel) return m_slot * (1 << (ROM_W - SB)) + pre % (1 << (ROM_W - SB));
        return pre;
    endfunction

    function automatic int expRam();
        if (m_sel) return m_slot * (1 << (RAM_W - SB)) + m_ram % (1 << (RAM_W - SB));
        return (m_ram % (1 << CB)) % (1 << RAM_W);
    endfunction

    function automatic int expRamCs(input int addr);
        if (addr >= 'hA000 && addr < 'hC000 && m_ram_en && ((m_ram >> CB) % 2) == 0) return 0;
        return 1;
    endfunction

    task automatic modelReset();
        m_rom = 1; m_ram = 0; m_slot = 0; m_pulse = 0;
        m_ram_en = 0; m_sel = 0; m_locked = 0;
    endtask

    task automatic modelCommit(input int a, input int d);
        int n;
        bit win;
        n   = (a >> 12) % 16;
        win = ((m_ram >> CB) % 2 == 1) && !m_locked;
        case (n)
            0, 1: m_ram_en = (d % 16) == 10;
            2:    m_rom = (m_rom / 256) * 256 + d;
            3:    m_rom = (m_rom % 256) + (d % 2) * 256;
            4, 5: begin
                m_ram = d % (1 << CB);
                if (!m_sel && !m_locked) m_ram += ((d >> CB) % 2) * (1 << CB);
                if (win && n == 4) m_pulse = R;
            end
            10: if (win) begin
                m_sel = d % 2;
                m_locked = m_locked || (d >= 128);
            end
            11: if (win) m_slot = d % (1 << SB);
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge osc_sig);
        #1;
        cyc++;
        if (m_pulse > 0) m_pulse--;
    endtask

    task automatic startWrite(input int a, input int d);
        bus.GB_A   = 16'(a);
        bus.GB_D   = 8'(d);
        bus.nGB_WR = 1'b0;
        repeat (4) tick();
        bus.nGB_WR = 1'b1;
        repeat (SS) tick();
        pend_a = a;
        pend_d = d;
    endtask

    task automatic finishWrite();
        tick();
        modelCommit(pend_a, pend_d);
    endtask

    task automatic applyStimulus(input int a, input int d);
        startWrite(a, d);
        finishWrite();
    endtask

    task automatic checkRead(input int addr);
        bus.GB_A = 16'(addr);
        #1;
        checkOutput($sformatf("rom_a@%h", addr), 32'(bus.ROM_A), expRom(addr));
        checkOutput($sformatf("ram_a@%h", addr), 32'(bus.RAM_A), expRam());
        checkOutput($sformatf("nrom_cs@%h", addr), 32'(bus.nROM_CS), (addr >= 'h8000) ? 1 : 0);
        checkOutput($sformatf("nram_cs@%h", addr), 32'(bus.nRAM_CS), expRamCs(addr));
        checkOutput("rst_oe", 32'(bus.GB_RST_oe), (m_pulse > 0) ? 1 : 0);
        checkOutput("rst_o", 32'(bus.GB_RST_o), 0);
    endtask

    task automatic doReset();
        bus.nGB_WR = 1'b1;
        rst = 1'b1;
        modelReset();
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic measurePulse(input int t0, input string tag, input int expected);
        while (bus.GB_RST_oe === 1'b1 && (cyc - t0) < 4 * R) tick();
        checkOutput(tag, cyc - t0, expected);
    endtask

    initial begin
        int t0, a, d, nib;
        int nibs[8] = '{0, 1, 2, 3, 4, 5, 10, 11};
        rst        = 1'b1;
        bus.GB_A   = 16'h0000;
        bus.GB_D   = 8'h00;
        bus.nGB_WR = 1'b1;
        modelReset();

        doReset();
        checkRead('h4000);
        checkRead('h0000);
        checkRead('hA000);

        // ROM bank write appears exactly SYNC_STAGES+1 edges after the strobe rises
        startWrite('h2000, 'h05);
        bus.GB_A = 16'h4000;
        #1;
        checkOutput("t1_early", 32'(bus.ROM_A), 1);
        finishWrite();
        checkOutput("t1_rom", 32'(bus.ROM_A), 'h05);
        checkRead('h4000);
        checkRead('h0000);

        applyStimulus('h0000, 'h0A);
        applyStimulus('h4000, 'h03);
        checkRead('hA000);
        checkOutput("t2_cs_on", 32'(bus.nRAM_CS), 0);
        checkOutput("t2_ram_a", 32'(bus.RAM_A), 3);
        applyStimulus('h0000, 'h00);
        checkRead('hA000);
        checkOutput("t2_cs_off", 32'(bus.nRAM_CS), 1);

        applyStimulus('h4000, 'h10);
        applyStimulus('hB000, 'h02);
        applyStimulus('hA000, 'h01);
        applyStimulus('h2000, 'h07);
        checkRead('h4000);
        checkOutput("t3_rom_a", 32'(bus.ROM_A), 'h107);
        checkOutput("t3_ram_top", 32'(bus.RAM_A >> 2), 2);
        checkRead('h1000);

        // Host reset pulse: single, then retriggered mid-pulse
        doReset();
        applyStimulus('h4000, 'h10);
        checkOutput("t4_no_pulse", 32'(bus.GB_RST_oe), 0);
        applyStimulus('h4000, 'h10);
        t0 = cyc;
        checkOutput("t4_oe_on", 32'(bus.GB_RST_oe), 1);
        measurePulse(t0, "t4_len", R);
        checkRead('h4000);
        applyStimulus('h4000, 'h10);
        t0 = cyc;
        while ((cyc - t0) < RETRIG - (4 + SS + 1)) tick();
        applyStimulus('h4000, 'h10);
        measurePulse(t0, "t4_retrig_len", RETRIG + R);
        checkRead('h4000);

        // Lock is one-way until rst
        doReset();
        applyStimulus('h4000, 'h10);
        applyStimulus('hB000, 'h01);
        applyStimulus('hA000, 'h81);
        checkRead('h4000);
        checkOutput("t5_rom_a", 32'(bus.ROM_A), 'h81);
        applyStimulus('h4000, 'h10);
        checkOutput("t5_no_pulse", 32'(bus.GB_RST_oe), 0);
        applyStimulus('hB000, 'h03);
        checkRead('h4000);
        checkOutput("t5_slot_kept", 32'(bus.ROM_A), 'h81);
        doReset();
        applyStimulus('h4000, 'h10);
        applyStimulus('hA000, 'h01);
        applyStimulus('hB000, 'h02);
        checkRead('h4000);
        checkOutput("t5_unlocked", 32'(bus.ROM_A), 'h101);

        // rst mid-pulse with slots enabled clears everything immediately
        doReset();
        applyStimulus('h4000, 'h10);
        applyStimulus('h4000, 'h10);
        applyStimulus('hB000, 'h03);
        applyStimulus('hA000, 'h01);
        checkRead('h4000);
        checkOutput("t6_pre_rom", 32'(bus.ROM_A), 'h181);
        checkOutput("t6_pre_oe", 32'(bus.GB_RST_oe), 1);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("t6_oe", 32'(bus.GB_RST_oe), 0);
        checkOutput("t6_rom", 32'(bus.ROM_A), 1);
        checkOutput("t6_ram", 32'(bus.RAM_A), 0);
        tick();
        rst = 1'b0;
        tick();
        checkRead('h4000);

        // Random writes checked against the model
        doReset();
        for (int i = 0; i < 150; i++) begin
            nib = nibs[$urandom_range(0, 7)];
            a = nib * 'h1000 + $urandom_range(0, 'hFFF);
            d = $urandom_range(0, 255);
            if (nib == 10 && $urandom_range(0, 7) != 0) d = d % 128;
            applyStimulus(a, d);
            repeat ($urandom_range(0, 3)) tick();
            checkRead($urandom_range(0, 'hFFFF));
            checkRead('hA000 + $urandom_range(0, 'h1FFF));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
